// File: rtl/call_arbiter_pkg.sv
// Shared sizing, call-entry layout and helpers for the call arbiter slice.
// Widths here must match the return arbiter's sequence buffer.
package call_arb_pkg;

    localparam int unsigned THREAD     = 16;
    localparam int unsigned SEQBUF     = 4;
    localparam int unsigned DATA       = 32;
    localparam int unsigned PARENT     = 64;
    localparam int unsigned CHILD      = 64;
    localparam int unsigned SEQ        = 2 * SEQBUF;

    localparam int unsigned LOG_THREAD = $clog2(THREAD);
    localparam int unsigned LOG_SEQ    = $clog2(SEQ);
    localparam int unsigned LOG_SEQBUF = $clog2(SEQBUF);
    localparam int unsigned LOG_PARENT = $clog2(PARENT);
    localparam int unsigned LOG_CHILD  = $clog2(CHILD);
    // Outstanding counter must reach SEQBUF itself, hence the +1.
    localparam int unsigned LOG_CRED   = $clog2(SEQBUF + 1);

    typedef enum logic {
        MODE_NONFIFO = 1'b0,
        MODE_FIFO    = 1'b1
    } call_mode_t;

    typedef struct packed {
        logic [LOG_PARENT-1:0] parent;
        logic [LOG_THREAD-1:0] thread;
        logic [LOG_SEQ-1:0]    seq;
        logic                  mode;
        logic [DATA-1:0]       args;
    } call_entry_t;

    function automatic logic [LOG_SEQ-1:0] seq_inc(input logic [LOG_SEQ-1:0] s);
        return (s == LOG_SEQ'(SEQ - 1)) ? '0 : s + LOG_SEQ'(1);
    endfunction

endpackage

// File: rtl/call_arbiter_if.sv
// Parent-side call requests and child-side dispatch bundle.
// slave = the arbiter, master = the parents/children around it.
interface call_arbiter_if;
    import call_arb_pkg::*;

    logic [PARENT-1:0]                 parentCall_i;
    logic [PARENT-1:0][LOG_CHILD-1:0]  parentCallChild_i;
    logic [PARENT-1:0][LOG_THREAD-1:0] parentCallThread_i;
    logic [PARENT-1:0]                 parentCallMode_i;
    logic [PARENT-1:0][DATA-1:0]       parentCallArgs_i;
    logic [PARENT-1:0]                 parentCallRdy_o;

    logic [CHILD-1:0]                  childCall_o;
    logic [CHILD-1:0][LOG_PARENT-1:0]  childParent_o;
    logic [CHILD-1:0][LOG_THREAD-1:0]  childThread_o;
    logic [CHILD-1:0][LOG_SEQ-1:0]     childSeq_o;
    logic [CHILD-1:0]                  childMode_o;
    logic [CHILD-1:0][DATA-1:0]        childArgs_o;
    logic [CHILD-1:0]                  childCallRdy_i;

    modport slave (
        input  parentCall_i, parentCallChild_i, parentCallThread_i,
               parentCallMode_i, parentCallArgs_i, childCallRdy_i,
        output parentCallRdy_o, childCall_o, childParent_o, childThread_o,
               childSeq_o, childMode_o, childArgs_o
    );

    modport master (
        output parentCall_i, parentCallChild_i, parentCallThread_i,
               parentCallMode_i, parentCallArgs_i, childCallRdy_i,
        input  parentCallRdy_o, childCall_o, childParent_o, childThread_o,
               childSeq_o, childMode_o, childArgs_o
    );

endinterface

// File: rtl/call_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: picks the first requester at or after the
// pointer; the pointer moves to grant+1 only when something is granted.
module callArb_rr_arbiter #(
    parameter int unsigned MUX_NUM = 4,
    parameter bit          REG_OUT = 1'b0,
    localparam int unsigned LOG_MUX = (MUX_NUM > 1) ? $clog2(MUX_NUM) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [MUX_NUM-1:0] sel,
    output logic               vld_o,
    output logic [LOG_MUX-1:0] vldPtr_o
);

    logic [LOG_MUX-1:0] r_ptr;
    logic [LOG_MUX-1:0] w_idx;
    logic [LOG_MUX-1:0] w_ptr_nxt;
    logic               w_vld;
    int unsigned        w_k;

    always_comb begin
        w_vld = 1'b0;
        w_idx = '0;
        w_k   = 0;
        for (int unsigned i = 0; i < MUX_NUM; i++) begin
            w_k = 32'(r_ptr) + i;
            if (w_k >= MUX_NUM) w_k = w_k - MUX_NUM;
            if (!w_vld && sel[w_k[LOG_MUX-1:0]]) begin
                w_vld = 1'b1;
                w_idx = w_k[LOG_MUX-1:0];
            end
        end
    end

    assign w_ptr_nxt = (w_idx == LOG_MUX'(MUX_NUM - 1)) ? '0 : w_idx + LOG_MUX'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      r_ptr <= '0;
        else if (w_vld) r_ptr <= w_ptr_nxt;
    end

    if (REG_OUT) begin : g_reg_out
        logic               r_vld;
        logic [LOG_MUX-1:0] r_idx;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_vld <= 1'b0;
                r_idx <= '0;
            end else begin
                r_vld <= w_vld;
                r_idx <= w_idx;
            end
        end
        assign vld_o    = r_vld;
        assign vldPtr_o = r_idx;
    end else begin : g_comb_out
        assign vld_o    = w_vld;
        assign vldPtr_o = w_idx;
    end

endmodule

// File: rtl/call_arbiter.sv
// Dispatches parent calls to child ports, stamping per-thread sequence/mode
// and enforcing return-buffer credits (SEQBUF in FIFO mode, one otherwise).
module call_arbiter
    import call_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    call_arbiter_if.slave     cif,
    input  logic [THREAD-1:0] retDone_i,
    output logic [THREAD-1:0] call_error_o
);

    call_entry_t               r_child [CHILD];
    logic [CHILD-1:0]          r_child_vld;
    logic [LOG_SEQ-1:0]        r_seq   [THREAD];
    logic [LOG_CRED-1:0]       r_out   [THREAD];
    logic [THREAD-1:0]         r_err;

    logic [PARENT-1:0]         w_elig;
    logic                      w_gnt_vld;
    logic [LOG_PARENT-1:0]     w_gnt_idx;
    logic [LOG_CHILD-1:0]      w_g_child;
    logic [LOG_THREAD-1:0]     w_g_thread;
    logic                      w_g_mode;
    call_entry_t               w_entry;
    logic [THREAD-1:0]         w_thr_gnt;
    logic [THREAD-1:0]         w_thr_ret;

    // A busy child still counts as free when it is being drained this cycle.
    always_comb begin
        w_elig = '0;
        for (int unsigned p = 0; p < PARENT; p++) begin
            w_elig[p] = cif.parentCall_i[p]
                && (!r_child_vld[cif.parentCallChild_i[p]]
                    || cif.childCallRdy_i[cif.parentCallChild_i[p]])
                && ((cif.parentCallMode_i[p] == MODE_FIFO)
                    ? (r_out[cif.parentCallThread_i[p]] < LOG_CRED'(SEQBUF))
                    : (r_out[cif.parentCallThread_i[p]] == '0));
        end
    end

    callArb_rr_arbiter #(
        .MUX_NUM (PARENT),
        .REG_OUT (1'b0)
    ) u_rr (
        .clk      (clk),
        .rstn     (rstn),
        .sel      (w_elig),
        .vld_o    (w_gnt_vld),
        .vldPtr_o (w_gnt_idx)
    );

    assign w_g_child  = cif.parentCallChild_i[w_gnt_idx];
    assign w_g_thread = cif.parentCallThread_i[w_gnt_idx];
    assign w_g_mode   = cif.parentCallMode_i[w_gnt_idx];

    always_comb begin
        w_entry        = '0;
        w_entry.parent = w_gnt_idx;
        w_entry.thread = w_g_thread;
        w_entry.seq    = r_seq[w_g_thread];
        w_entry.mode   = w_g_mode;
        w_entry.args   = cif.parentCallArgs_i[w_gnt_idx];
    end

    always_comb begin
        cif.parentCallRdy_o = '0;
        if (w_gnt_vld) cif.parentCallRdy_o[w_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_child_vld <= '0;
            for (int unsigned c = 0; c < CHILD; c++) r_child[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < CHILD; c++) begin
                if (w_gnt_vld && (w_g_child == LOG_CHILD'(c))) begin
                    r_child_vld[c] <= 1'b1;
                    r_child[c]     <= w_entry;
                end else if (cif.childCallRdy_i[c]) begin
                    r_child_vld[c] <= 1'b0;
                end
            end
        end
    end

    assign cif.childCall_o = r_child_vld;

    always_comb begin
        for (int unsigned c = 0; c < CHILD; c++) begin
            cif.childParent_o[c] = r_child[c].parent;
            cif.childThread_o[c] = r_child[c].thread;
            cif.childSeq_o[c]    = r_child[c].seq;
            cif.childMode_o[c]   = r_child[c].mode;
            cif.childArgs_o[c]   = r_child[c].args;
        end
    end

    // A return with nothing outstanding is flagged and otherwise ignored.
    always_comb begin
        w_thr_gnt = '0;
        w_thr_ret = '0;
        for (int unsigned t = 0; t < THREAD; t++) begin
            w_thr_gnt[t] = w_gnt_vld && (w_g_thread == LOG_THREAD'(t));
            w_thr_ret[t] = retDone_i[t] && (r_out[t] != '0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
            for (int unsigned t = 0; t < THREAD; t++) begin
                r_seq[t] <= '0;
                r_out[t] <= '0;
            end
        end else begin
            for (int unsigned t = 0; t < THREAD; t++) begin
                r_err[t] <= retDone_i[t] && (r_out[t] == '0);
                if (w_thr_gnt[t] && (w_g_mode == MODE_FIFO))
                    r_seq[t] <= seq_inc(r_seq[t]);
                if (w_thr_gnt[t] && !w_thr_ret[t])
                    r_out[t] <= r_out[t] + LOG_CRED'(1);
                else if (!w_thr_gnt[t] && w_thr_ret[t])
                    r_out[t] <= r_out[t] - LOG_CRED'(1);
            end
        end
    end

    assign call_error_o = r_err;

endmodule

// File: tb/tb_call_arbiter.sv
// Scoreboard bench for call_arbiter: expected child entries are queued at
// grant time and matched per child when the child handshake completes.
module tb_call_arbiter;
    import call_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [THREAD-1:0] retDone;
    logic [THREAD-1:0] call_error;

    call_arbiter_if u_if();

    call_arbiter u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .cif          (u_if),
        .retDone_i    (retDone),
        .call_error_o (call_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          child;
        logic [63:0] val;
    } exp_t;

    exp_t               sb[$];
    logic [LOG_SEQ-1:0] m_seq [THREAD];

    function automatic logic [63:0] pack(input int p, input int t, input int s,
                                         input int m, input logic [31:0] a);
        return 64'({LOG_PARENT'(p), LOG_THREAD'(t), LOG_SEQ'(s), 1'(m), DATA'(a)});
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int c = 0; c < CHILD; c++) begin
                if (u_if.childCall_o[c] && u_if.childCallRdy_i[c]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].child == c) idx = k;
                    if (idx < 0) begin
                        check($sformatf("unexpected_child%0d", c), 64'(u_if.childCall_o[c]), 64'd0);
                    end else begin
                        check($sformatf("child%0d_entry", c),
                              pack(int'(u_if.childParent_o[c]), int'(u_if.childThread_o[c]),
                                   int'(u_if.childSeq_o[c]), int'(u_if.childMode_o[c]),
                                   u_if.childArgs_o[c]),
                              sb[idx].val);
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    // Starts and ends one cycle phase after a rising edge.
    task automatic do_call(input int p, input int t, input int c, input int m,
                           input logic [31:0] a, input int max_wait, output int gcyc);
        int waited;
        logic [LOG_SEQ-1:0] s;
        u_if.parentCallChild_i[p]  = LOG_CHILD'(c);
        u_if.parentCallThread_i[p] = LOG_THREAD'(t);
        u_if.parentCallMode_i[p]   = 1'(m);
        u_if.parentCallArgs_i[p]   = a;
        u_if.parentCall_i[p]       = 1'b1;
        waited = 0;
        gcyc   = -1;
        while (gcyc < 0 && waited <= max_wait) begin
            @(negedge clk);
            if (u_if.parentCallRdy_o[p]) gcyc = cyc;
            else waited++;
        end
        if (gcyc < 0) begin
            check($sformatf("timeout_p%0d", p), 64'(u_if.parentCallRdy_o[p]), 64'd1);
        end else begin
            check($sformatf("rdy_p%0d", p), 64'(u_if.parentCallRdy_o), 64'd1 << p);
            s = m_seq[t];
            sb.push_back('{c, pack(p, t, int'(s), m, a)});
            if (m != 0) m_seq[t] = s + 1'b1;
        end
        @(posedge clk);
        #1;
        u_if.parentCall_i[p] = 1'b0;
    endtask

    task automatic ret_pulse(input int t, output int rc);
        retDone[t] = 1'b1;
        rc = cyc;
        @(posedge clk);
        #1;
        retDone[t] = 1'b0;
    endtask

    task automatic do_reset(input bit drain);
        if (drain) begin
            repeat (2) @(posedge clk);
            #1;
            check("drain", 64'(sb.size()), 64'd0);
        end
        rstn                    = 1'b0;
        u_if.parentCall_i       = '0;
        u_if.parentCallChild_i  = '0;
        u_if.parentCallThread_i = '0;
        u_if.parentCallMode_i   = '0;
        u_if.parentCallArgs_i   = '0;
        u_if.childCallRdy_i     = '1;
        retDone                 = '0;
        sb.delete();
        for (int t = 0; t < THREAD; t++) m_seq[t] = '0;
        @(negedge clk);
        check("rst_childCall", 64'(u_if.childCall_o), 64'd0);
        check("rst_parentRdy", 64'(u_if.parentCallRdy_o), 64'd0);
        check("rst_error", 64'(call_error), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g, g2, ga, gb, gc, rc, s0;

        do_reset(1'b0);

        // single FIFO call
        s0 = cyc;
        do_call(3, 5, 7, 1, 32'hA5, 20, g);
        check("single_gnt_cycle", 64'(g), 64'(s0));
        check("single_childCall7", 64'(u_if.childCall_o[7]), 64'd1);
        check("single_seq", 64'(u_if.childSeq_o[7]), 64'd0);

        // credit limit on thread 2
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            s0 = cyc;
            do_call(1, 2, 10, 1, 32'h100 + i, 5, g);
            check($sformatf("credit_gnt%0d", i), 64'(g), 64'(s0));
        end
        fork
            do_call(1, 2, 10, 1, 32'h104, 40, g2);
            begin
                repeat (6) @(posedge clk);
                #1;
                ret_pulse(2, rc);
            end
        join
        check("credit_stall", 64'(g2), 64'(rc + 1));

        // sequence wrap on thread 0
        do_reset(1'b1);
        for (int i = 0; i < 9; i++) begin
            do_call(0, 0, 12, 1, 32'(i), 5, g);
            if (i >= 7) check($sformatf("wrap_seq%0d", i), 64'(u_if.childSeq_o[12]), 64'(i % 8));
            ret_pulse(0, rc);
        end

        // non-FIFO blocking on thread 1
        do_reset(1'b1);
        do_call(4, 1, 20, 0, 32'hBEEF, 5, g);
        check("nf_mode", 64'(u_if.childMode_o[20]), 64'd0);
        fork
            do_call(4, 1, 21, 0, 32'hCAFE, 40, g2);
            begin
                repeat (4) @(posedge clk);
                #1;
                ret_pulse(1, rc);
            end
        join
        check("nf_stall", 64'(g2), 64'(rc + 1));

        // contention on child 4, always ready
        do_reset(1'b1);
        s0 = cyc;
        fork
            do_call(0, 8, 4, 1, 32'h10, 20, ga);
            do_call(1, 9, 4, 1, 32'h11, 20, gb);
            do_call(2, 10, 4, 1, 32'h12, 20, gc);
        join
        check("cont_p0", 64'(ga), 64'(s0));
        check("cont_p1", 64'(gb), 64'(ga + 1));
        check("cont_p2", 64'(gc), 64'(gb + 1));

        // contention on child 4, held not ready
        repeat (2) @(posedge clk);
        #1;
        u_if.childCallRdy_i[4] = 1'b0;
        fork
            do_call(0, 8, 4, 1, 32'h20, 40, ga);
            do_call(1, 9, 4, 1, 32'h21, 40, gb);
            do_call(2, 10, 4, 1, 32'h22, 40, gc);
            begin
                repeat (5) @(negedge clk);
                check("hold_vld", 64'(u_if.childCall_o[4]), 64'd1);
                check("hold_parent", 64'(u_if.childParent_o[4]), 64'd0);
                @(posedge clk);
                #1;
                u_if.childCallRdy_i[4] = 1'b1;
            end
        join
        check("hold_p1", 64'(gb), 64'(ga + 5));
        check("hold_p2", 64'(gc), 64'(gb + 1));

        // spurious return and same-cycle grant/return on thread 6
        do_reset(1'b1);
        ret_pulse(6, rc);
        check("err_set", 64'(call_error), 64'd1 << 6);
        @(posedge clk);
        #1;
        check("err_clear", 64'(call_error), 64'd0);
        for (int i = 0; i < 3; i++) do_call(5, 6, 30, 1, 32'h600 + i, 5, g);
        fork
            do_call(5, 6, 30, 1, 32'h603, 5, g);
            ret_pulse(6, rc);
        join
        check("conc_same_cycle", 64'(g), 64'(rc));
        check("conc_no_err", 64'(call_error), 64'd0);
        s0 = cyc;
        do_call(5, 6, 30, 1, 32'h604, 5, g);
        check("conc_credit_left", 64'(g), 64'(s0));
        fork
            do_call(5, 6, 30, 1, 32'h605, 40, g2);
            begin
                repeat (3) @(posedge clk);
                #1;
                ret_pulse(6, rc);
            end
        join
        check("conc_full_stall", 64'(g2), 64'(rc + 1));

        // reset while a call is held at a child
        do_reset(1'b1);
        u_if.childCallRdy_i[40] = 1'b0;
        do_call(7, 3, 40, 1, 32'h77, 5, g);
        check("midrst_pre", 64'(u_if.childCall_o[40]), 64'd1);
        rstn = 1'b0;
        #1;
        check("midrst_clear", 64'(u_if.childCall_o), 64'd0);
        do_reset(1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/call_arbiter.md
Name: call_arbiter

Overview:
- Upstream companion of the return arbiter. Accepts call requests from PARENT parent ports and dispatches each one to its target child.
- Per thread, stamps each call with a call sequence number (mod SEQ) and a mode bit. The return arbiter later uses these to reorder the child's results.
- Tracks outstanding calls per thread and enforces credit limits matching the return sequence buffer: SEQBUF slots in FIFO mode, one call in non-FIFO mode.

Parameters:
THREAD, 16, number of threads
SEQBUF, 4, return-buffer slots per thread (max outstanding FIFO calls)
DATA, 32, argument width
PARENT, 64, number of parent ports
CHILD, 64, number of child ports
SEQ, 2*SEQBUF, sequence number modulus
LOG_THREAD/LOG_SEQ/LOG_SEQBUF/LOG_PARENT/LOG_CHILD, $clog2 of the above, derived

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
parentCall_i  in  [PARENT]  call request per parent
parentCallChild_i  in  LOG_CHILD x[PARENT]  target child index
parentCallThread_i  in  LOG_THREAD x[PARENT]  calling thread
parentCallMode_i  in  1 x[PARENT]  1=FIFO mode, 0=non-FIFO mode
parentCallArgs_i  in  DATA x[PARENT]  call argument
parentCallRdy_o  out  [PARENT]  accept pulse
childCall_o  out  1 x[CHILD]  call valid to child
childParent_o  out  LOG_PARENT x[CHILD]  originating parent
childThread_o  out  LOG_THREAD x[CHILD]  thread
childSeq_o  out  LOG_SEQ x[CHILD]  call sequence
childMode_o  out  1 x[CHILD]  mode
childArgs_o  out  DATA x[CHILD]  argument
childCallRdy_i  in  1 x[CHILD]  child accepts call
retDone_i  in  [THREAD]  one return popped by the parent for the thread; releases one credit
call_error_o  out  [THREAD]  registered error flag per thread

Behaviour:
- Interface: one clock clk; reset rstn is asynchronous and active-low.
- Reset values: all outputs 0. callSeq_r[t]=0, outstanding_r[t]=0, round-robin pointer=0.
- Eligibility: parent p is eligible when all of the following hold:
  - parentCall_i[p]=1.
  - Child register c=parentCallChild_i[p] is free: childCall_o[c]=0, or childCall_o[c]&childCallRdy_i[c] in the same cycle.
  - Thread t has credit: FIFO mode needs outstanding_r[t]<SEQBUF; non-FIFO mode needs outstanding_r[t]==0.
- Arbitration:
  - A single round-robin arbiter over eligible parents grants at most one call per cycle.
  - The pointer advances to grant+1 (wrapping at PARENT) only when a grant occurs.
  - The arbiter output is combinational (REG_OUT=0).
- Accept: parentCallRdy_o[p]=1 in the grant cycle only. It depends combinationally on parentCall_i, so parents must not gate their call on rdy.
- Dispatch (grant in cycle N):
  - Child c output register loads {p, t, seq, mode, args}; childCall_o[c]=1 from cycle N+1.
  - The output holds until childCallRdy_i[c]=1, then clears the next cycle unless refilled by a new grant in that same cycle.
- Sequence numbering:
  - FIFO call: seq=callSeq_r[t], then callSeq_r[t]+=1, wrapping SEQ-1 -> 0.
  - Non-FIFO call: seq=callSeq_r[t], and callSeq_r[t] is unchanged (the return arbiter ignores seq in this mode).
- Credits:
  - outstanding_r[t] +1 on grant, -1 on retDone_i[t].
  - Grant and retDone on the same thread in the same cycle: net 0.
  - retDone_i[t] with outstanding_r[t]==0: count stays 0, and call_error_o[t]=1 for one cycle (registered, next cycle).
- Mixed modes on one thread: a non-FIFO call waits until all FIFO calls of that thread have returned.
- Reset mid-operation clears all in-flight outputs and credits; no recovery state.

Decomposition:
- Package call_arb_pkg: parameter defaults, derived LOG_* widths, packed struct call_entry_t {parent, thread, seq, mode, args} used for the child output registers.
- Sub-module callArb_rr_arbiter (MUX_NUM, REG_OUT): generic round-robin arbiter with interface sel/vld_o/vldPtr_o, instantiated once with MUX_NUM=PARENT, REG_OUT=0.

Test Plan:
- Single FIFO call: parent 3, thread 5, child 7, args 0xA5 at cycle 0 -> parentCallRdy_o[3]=1 in cycle 0; childCall_o[7]=1 at cycle 1 with thread 5, seq 0, mode 1, parent 3; outstanding[5]=1.
- Credit limit: thread 2 issues 5 FIFO calls with children always ready and no retDone -> 4 dispatched with seq 0,1,2,3; 5th stalls until retDone_i[2], then dispatches with seq 4.
- Seq wrap: 9 FIFO calls on thread 0, each returned -> seqs 0..7 then 0.
- Non-FIFO blocking: thread 1 issues a non-FIFO call, then a second one -> second stalls until retDone_i[1]; both carry the same seq.
- Contention: parents 0, 1, 2 all request child 4 while child 4 is always ready -> grants in order 0, 1, 2 on consecutive cycles. With childCallRdy_i[4]=0, only parent 0 is granted and childCall_o[4] holds.
- Error and concurrency: retDone_i[6] with no outstanding calls -> call_error_o[6]=1 for exactly one cycle. A same-cycle grant and retDone on thread 6 leaves outstanding unchanged.
